// File: rtl/shake_squeeze_buffer.sv
// Captures SHAKE256 rate blocks and streams them out as W-bit words until the
// requested byte count is emitted, asking the core for more blocks as needed.
module shake_squeeze_buffer #(
    parameter int W    = 64,
    parameter int RATE = 1088
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       out_len,
    input  logic [RATE-1:0]   hash_in,
    input  logic              squeezed,
    output logic              squeeze_req,
    output logic              busy,
    output logic [W-1:0]      m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [W/8-1:0]    m_keep,
    output logic              done,
    output logic              overrun
);

    localparam int WORDS = RATE / W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [15:0]      BPW      = 16'(W / 8);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, REQ} state_t;

    state_t            state;
    logic [RATE-1:0]   blk;
    logic [IDX_W-1:0]  idx;
    logic [15:0]       rem;
    logic              hs;
    logic              is_last;

    assign hs      = m_valid & m_ready;
    assign is_last = (rem <= BPW);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            blk         <= '0;
            idx         <= '0;
            rem         <= '0;
            busy        <= 1'b0;
            m_valid     <= 1'b0;
            squeeze_req <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done        <= 1'b0;
            squeeze_req <= 1'b0;
            // A block arriving when we are not waiting for one is dropped and flagged.
            if (squeezed && state != WAIT)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (out_len != 16'd0) begin
                            rem     <= out_len;
                            idx     <= '0;
                            overrun <= 1'b0;
                            busy    <= 1'b1;
                            state   <= WAIT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (squeezed) begin
                        blk     <= hash_in;
                        idx     <= '0;
                        m_valid <= 1'b1;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (is_last) begin
                            rem     <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            m_valid <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            rem <= rem - BPW;
                            if (idx == LAST_IDX) begin
                                idx         <= '0;
                                m_valid     <= 1'b0;
                                squeeze_req <= 1'b1;
                                state       <= REQ;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                end
                REQ:     state <= WAIT;
                default: state <= IDLE;
            endcase
        end
    end

    // Lane 0 sits in the top bits of the block; keep marks leading valid bytes.
    always_comb begin
        m_data = blk[RATE-1-W*int'(idx) -: W];
        m_last = m_valid & is_last;
        m_keep = '0;
        for (int b = 0; b < W/8; b++)
            m_keep[W/8-1-b] = m_valid & (!is_last || (16'(b) < rem));
    end

endmodule
